// File: rtl/memctrl_arb.sv
// memctrl_arb: fixed-priority multi-port arbiter serialising multi-byte accesses onto a byte-wide memory
module memctrl_arb #(
    parameter int ADDR_W    = 32,
    parameter int NUM_PORTS = 2,
    parameter int MAX_BYTES = 4,
    parameter int LEN_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           req,
    input  logic [NUM_PORTS-1:0]           rw,
    input  logic [NUM_PORTS*ADDR_W-1:0]    addr,
    input  logic [NUM_PORTS*LEN_W-1:0]     len,
    input  logic [NUM_PORTS*8*MAX_BYTES-1:0] wdata,
    input  logic [NUM_PORTS-1:0]           abort,
    output logic [NUM_PORTS-1:0]           done,
    output logic [8*MAX_BYTES-1:0]         rdata,
    output logic                           busy,
    input  logic [7:0]                     mem_din,
    output logic                           mem_wr,
    output logic [ADDR_W-1:0]              mem_a,
    output logic [7:0]                     mem_dout
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    typedef enum logic [1:0] {IDLE, XFER, WAIT, DONE} state_t;
    state_t state, state_nx;
    logic [PW-1:0]          gnt, sel;
    logic                   rw_q, sel_rw, pend, abort_g, last;
    logic [ADDR_W-1:0]      addr_q, sel_addr;
    logic [LEN_W-1:0]       len_q, sel_len, cnt, pidx;
    logic [8*MAX_BYTES-1:0] wdata_q, sel_wdata;
    assign abort_g = abort[gnt];
    assign last    = cnt == len_q;
    // pick the lowest-index requester and expose its operands for latching
    always_comb begin
        sel       = '0;
        sel_rw    = 1'b0;
        sel_addr  = '0;
        sel_len   = '0;
        sel_wdata = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (req[p]) begin
                sel       = PW'(p);
                sel_rw    = rw[p];
                sel_addr  = addr[p*ADDR_W +: ADDR_W];
                sel_len   = len[p*LEN_W +: LEN_W];
                sel_wdata = wdata[p*8*MAX_BYTES +: 8*MAX_BYTES];
            end
        end
    end
    // state register
    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
    // next state plus memory-side and handshake outputs
    always_comb begin
        state_nx = state;
        done     = '0;
        busy     = state != IDLE;
        mem_wr   = 1'b0;
        mem_a    = '0;
        mem_dout = '0;
        case (state)
            IDLE: state_nx = |req ? XFER : IDLE;
            XFER: begin
                mem_wr   = rw_q;
                mem_a    = addr_q + ADDR_W'(cnt);
                mem_dout = rw_q ? wdata_q[{cnt, 3'b000} +: 8] : 8'h00;
                state_nx = abort_g ? IDLE : !last ? XFER : rw_q ? DONE : WAIT;
            end
            WAIT: state_nx = abort_g ? IDLE : DONE;
            DONE: begin
                done     = NUM_PORTS'(1) << gnt;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    // grant latching, byte counter and read assembly; a read byte lands one cycle after its address
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt     <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            wdata_q <= '0;
            cnt     <= '0;
            pend    <= 1'b0;
            pidx    <= '0;
            rdata   <= '0;
        end else begin
            if (state == IDLE && |req) begin
                gnt     <= sel;
                rw_q    <= sel_rw;
                addr_q  <= sel_addr;
                len_q   <= sel_len;
                wdata_q <= sel_wdata;
                cnt     <= '0;
            end else if (state == XFER) begin
                cnt <= cnt + LEN_W'(1);
            end
            pend <= state == XFER && !rw_q && !abort_g;
            pidx <= cnt;
            if (state == IDLE && |req && !sel_rw)
                rdata <= '0;
            else if (pend)
                rdata[{pidx, 3'b000} +: 8] <= mem_din;
        end
    end
endmodule

// File: tb/tb_memctrl_arb.sv
// tb_memctrl_arb: randomized transaction-level check of memctrl_arb against a scheduling/memory model
module tb_memctrl_arb;
    logic        clk = 1'b0, rst = 1'b1;
    logic [1:0]  req = '0, rw = '0, abort = '0, done;
    logic [63:0] addr = '0, wdata = '0;
    logic [3:0]  len = '0;
    logic [31:0] rdata, mem_a;
    logic        busy, mem_wr;
    logic [7:0]  mem_din = '0, mem_dout;
    int total = 0, bad = 0, cyc = 0;
    logic [7:0]  mem[logic [31:0]];
    logic [7:0]  ref_mem[logic [31:0]];
    logic [1:0]  en;
    logic        op_rw[2];
    logic [31:0] op_a[2], op_wd[2], exp_rd[2];
    int          op_len[2], op_ab[2], g_c[2], e_c[2];
    logic [31:0] rd_model;
    bit          rd_known;

    memctrl_arb dut (
        .clk(clk), .rst(rst), .req(req), .rw(rw), .addr(addr), .len(len), .wdata(wdata),
        .abort(abort), .done(done), .rdata(rdata), .busy(busy), .mem_din(mem_din),
        .mem_wr(mem_wr), .mem_a(mem_a), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // byte-wide memory: writes on the edge, read data presented the cycle after the address
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_wr) mem[mem_a] = mem_dout;
        mem_din <= mem.exists(mem_a) ? mem[mem_a] : dflt(mem_a);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_op(input int p, input logic w, input logic [31:0] a, input int l,
                          input logic [31:0] d, input int ab);
        op_rw[p] = w; op_a[p] = a; op_len[p] = l; op_wd[p] = d; op_ab[p] = ab;
    endtask

    // run the enabled ports' operations: schedule them from the arbitration rules, then check every cycle
    task automatic run();
        int t0, nxt, n, k;
        bit own, e_x, e_wr, e_busy;
        logic [1:0] e_done;
        logic [31:0] e_a;
        logic [7:0] e_do;
        @(posedge clk); #1;
        t0 = cyc; nxt = t0;
        for (int p = 0; p < 2; p++) if (en[p]) begin
            n = op_len[p] + 1; g_c[p] = nxt; exp_rd[p] = '0;
            if (op_ab[p] >= 0) begin
                e_c[p] = nxt + 1 + op_ab[p];
                if (op_rw[p]) for (int i = 0; i <= op_ab[p]; i++) ref_mem[op_a[p] + i] = op_wd[p][8*i +: 8];
            end else begin
                e_c[p] = nxt + n + 1 + (op_rw[p] ? 0 : 1);
                for (int i = 0; i < n; i++)
                    if (op_rw[p]) ref_mem[op_a[p] + i] = op_wd[p][8*i +: 8];
                    else exp_rd[p][8*i +: 8] = ref_rd(op_a[p] + i);
            end
            nxt = e_c[p] + 1;
        end
        for (int c = t0; c <= nxt + 1; c++) begin
            if (c != t0) begin @(posedge clk); #1; end
            for (int p = 0; p < 2; p++) begin
                own = en[p] && c > g_c[p] && c <= e_c[p];
                req[p] = en[p] && c <= e_c[p];
                abort[p] = own ? (op_ab[p] >= 0 && c == g_c[p] + 1 + op_ab[p]) : 1'($urandom_range(0, 1));
                if (en[p] && c <= g_c[p]) begin
                    rw[p] = op_rw[p]; addr[p*32 +: 32] = op_a[p];
                    len[p*2 +: 2] = 2'(op_len[p]); wdata[p*32 +: 32] = op_wd[p];
                end else begin
                    rw[p] = 1'($urandom); addr[p*32 +: 32] = $urandom;
                    len[p*2 +: 2] = 2'($urandom); wdata[p*32 +: 32] = $urandom;
                end
            end
            @(negedge clk);
            e_done = '0; e_x = 0; e_wr = 0; e_a = '0; e_do = '0; e_busy = 0;
            for (int p = 0; p < 2; p++) if (en[p]) begin
                n = op_len[p] + 1; k = c - g_c[p] - 1;
                if (c > g_c[p] && c <= e_c[p]) e_busy = 1;
                if (c > g_c[p] && k < n && c <= e_c[p]) begin
                    e_x = 1; e_wr = op_rw[p]; e_a = op_a[p] + k;
                    e_do = op_rw[p] ? op_wd[p][8*k +: 8] : 8'h00;
                end
                if (op_ab[p] < 0 && c == e_c[p]) e_done[p] = 1'b1;
            end
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("mem_wr", mem_wr, e_wr);
            chk("mem_a", mem_a, e_a);
            if (!e_x || e_wr) chk("mem_dout", mem_dout, e_do);
            for (int p = 0; p < 2; p++) if (en[p] && c == e_c[p]) begin
                if (op_ab[p] >= 0) begin
                    if (!op_rw[p]) rd_known = 0;
                end else if (!op_rw[p]) begin
                    chk("rdata", rdata, exp_rd[p]); rd_model = exp_rd[p]; rd_known = 1;
                end else if (rd_known) chk("rdata_hold", rdata, rd_model);
            end
        end
        req = '0; abort = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [31:0] ra;
        int rl;
        for (int i = 0; i < 4; i++) begin
            mem[32'h100 + i] = 8'(8'h11 * (i + 1));
            ref_mem[32'h100 + i] = 8'(8'h11 * (i + 1));
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_wr", mem_wr, 0);
        chk("rst_a", mem_a, 0); chk("rst_dout", mem_dout, 0); chk("rst_rdata", rdata, 0);
        @(posedge clk); #1 rst = 0;
        rd_model = '0; rd_known = 1;

        en = 2'b10; set_op(1, 0, 32'h100, 3, 0, -1); run();
        chk("t1_rdata", rdata, 32'h44332211);
        en = 2'b01; set_op(0, 1, 32'h20, 1, 32'hBEEF, -1); run();
        chk("t2_mem20", mem[32'h20], 8'hEF); chk("t2_mem21", mem[32'h21], 8'hBE);
        chk("t2_rdata", rdata, 32'h44332211);
        en = 2'b11; set_op(0, 1, 32'h40, 2, $urandom, -1); set_op(1, 0, 32'h20, 1, 0, -1); run();
        chk("t3_rdata", rdata, 32'h0000BEEF);
        en = 2'b10; set_op(1, 0, 32'h100, 3, 0, 1); run();
        en = 2'b01; set_op(0, 1, 32'hFFFFFFFE, 3, 32'hCAFEF00D, -1); run();
        set_op(0, 0, 32'h30, 0, 0, -1); run();
        chk("t5_upper", rdata[31:8], 0);
        en = 2'b10; set_op(1, 0, 32'hFFFFFFFE, 3, 0, -1); run();
        chk("t5_wrap", rdata, 32'hCAFEF00D);

        @(posedge clk); #1;
        req = 2'b01; rw = 2'b01; addr[31:0] = 32'h5000; len[1:0] = 2'd3; wdata[31:0] = 32'h87654321;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 req = '0;
        @(negedge clk);
        chk("rmid_busy", busy, 0); chk("rmid_done", done, 0); chk("rmid_wr", mem_wr, 0);
        chk("rmid_a", mem_a, 0); chk("rmid_dout", mem_dout, 0); chk("rmid_rdata", rdata, 0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("rpost_busy", busy, 0); chk("rpost_wr", mem_wr, 0); chk("rpost_done", done, 0);
        chk("rpost_mem5002", mem.exists(32'h5002), 0);
        ref_mem[32'h5000] = 8'h21; ref_mem[32'h5001] = 8'h43;
        rd_model = '0; rd_known = 1;

        for (int k = 0; k < 40; k++) begin
            en = 2'($urandom_range(1, 3));
            for (int p = 0; p < 2; p++) begin
                ra = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + $urandom_range(0, 3) : 32'($urandom_range(0, 63));
                rl = $urandom_range(0, 3);
                set_op(p, 1'($urandom), ra, rl, $urandom,
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rl)) : -1);
            end
            run();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
